logicnets_lut_layer_pipe: RTL and testbench

//  Parametrised, pipelined LogicNets layer: NUM_NEURONS truth-table neurons, each mapping
//  FAN_IN input bits to OUT_BITS output bits. Truth tables are loaded at runtime from a

---
 rtl/logicnets_pkg.sv | 24 ++
 rtl/logicnets_lut_neuron.sv | 53 +++++
 rtl/logicnets_lut_layer_pipe.sv | 173 +++++++++++++++++
 tb/tb_logicnets_lut_layer_pipe.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logicnets_pkg.sv
// ---------------------------------------------------------------------------
// logicnets_pkg
//   Shared definitions for the runtime-loadable LogicNets layer.
//   - state_e : load FSM states (IDLE serves lookups, LOAD streams table entries)
//   - clog2_f : constant-function ceil(log2(value)), minimum result 1 so that
//               derived counter widths are never zero.
// ---------------------------------------------------------------------------
package logicnets_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/logicnets_lut_neuron.sv
// ---------------------------------------------------------------------------
// logicnets_lut_neuron
//   One truth-table neuron: a 2**FAN_IN x OUT_BITS table held in flops.
//   Writes land on the rising clock edge; the read is purely combinational so
//   the enclosing layer registers the lookup result itself.
// Ports
//   clk    in  1         rising-edge clock
//   rst_n  in  1         async active-low reset, clears every entry to 0
//   we     in  1         write enable
//   waddr  in  FAN_IN    entry to write
//   wdata  in  OUT_BITS  value to write
//   raddr  in  FAN_IN    entry to read (the neuron's input bits)
//   rdata  out OUT_BITS  table[raddr]
// ---------------------------------------------------------------------------
module logicnets_lut_neuron #(
  parameter int FAN_IN   = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [FAN_IN-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [FAN_IN-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);

  localparam int DEPTH = 1 << FAN_IN;

  logic [OUT_BITS-1:0] tbl_q [DEPTH];
  logic [OUT_BITS-1:0] tbl_d [DEPTH];

  // One register per entry, each with its own address decode.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_comb begin
      tbl_d[gi] = tbl_q[gi];
      if (we && (waddr == FAN_IN'(gi))) begin
        tbl_d[gi] = wdata;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tbl_q[gi] <= '0;
      end else begin
        tbl_q[gi] <= tbl_d[gi];
      end
    end
  end

  assign rdata = tbl_q[raddr];

endmodule

// File: rtl/logicnets_lut_layer_pipe.sv
// ---------------------------------------------------------------------------
// logicnets_lut_layer_pipe
//   Pipelined LogicNets layer of NUM_NEURONS truth-table neurons whose tables
//   are streamed in at runtime. Lookups use valid/ready handshakes with a
//   single registered output stage (latency 1, one vector per cycle).
//
//   Tables are loaded as one bulk stream of ENTRIES words, neuron-major:
//   entry index = n*2**FAN_IN + addr. Lookups are blocked for the whole load
//   so no vector ever sees a half-written table.
//
// Ports
//   clk        in  1                     rising-edge clock
//   rst_n      in  1                     async active-low reset
//   s_valid    in  1                     input vector valid
//   s_ready    out 1                     layer accepts an input vector
//   s_data     in  NUM_NEURONS*FAN_IN    neuron n reads bits [n*FAN_IN +: FAN_IN]
//   m_valid    out 1                     output vector valid
//   m_ready    in  1                     downstream accepts the output
//   m_data     out NUM_NEURONS*OUT_BITS  neuron n drives bits [n*OUT_BITS +: OUT_BITS]
//   cfg_start  in  1                     request a bulk table load
//   cfg_valid  in  1                     cfg_data holds the next table entry
//   cfg_data   in  OUT_BITS              table entry value
//   cfg_busy   out 1                     load in progress
//   cfg_done   out 1                     one-cycle pulse after the final entry
//
// NUM_NEURONS must be a power of two so ENTRIES is too; the load counter then
// wraps back to zero on its own after the last entry.
// ---------------------------------------------------------------------------
module logicnets_lut_layer_pipe
  import logicnets_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int FAN_IN      = 6,
  parameter int OUT_BITS    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_NEURONS*FAN_IN-1:0]   s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] m_data,
  input  logic                            cfg_start,
  input  logic                            cfg_valid,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_busy,
  output logic                            cfg_done
);

  localparam int DEPTH   = 1 << FAN_IN;
  localparam int ENTRIES = NUM_NEURONS * DEPTH;
  localparam int CNT_W   = clog2_f(ENTRIES);
  // Upper counter bits select the neuron; zero-width for a single neuron.
  localparam int SEL_W   = CNT_W - FAN_IN;
  localparam int OUT_W   = NUM_NEURONS * OUT_BITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ENTRIES - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               cfg_done_q, cfg_done_d;
  logic               m_valid_q,  m_valid_d;
  logic [OUT_W-1:0]   m_data_q,   m_data_d;

  logic               load_wr;
  logic               xfer;
  logic [NUM_NEURONS-1:0] neuron_sel;
  logic [OUT_W-1:0]   lut_rdata;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  // Input is accepted only when idle and the output stage is free or being
  // emptied this same cycle.
  assign s_ready = (state_q == IDLE) && (!m_valid_q || m_ready);
  assign xfer    = s_valid && s_ready;
  assign load_wr = (state_q == LOAD) && cfg_valid;

  // -------------------------------------------------------------------------
  // Neuron array
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
    if (SEL_W == 0) begin : g_single
      assign neuron_sel[gi] = 1'b1;
    end else begin : g_multi
      assign neuron_sel[gi] = (cnt_q[CNT_W-1:FAN_IN] == SEL_W'(gi));
    end

    logicnets_lut_neuron #(
      .FAN_IN   (FAN_IN),
      .OUT_BITS (OUT_BITS)
    ) u_neuron (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (load_wr && neuron_sel[gi]),
      .waddr (cnt_q[FAN_IN-1:0]),
      .wdata (cfg_data),
      .raddr (s_data[gi*FAN_IN +: FAN_IN]),
      .rdata (lut_rdata[gi*OUT_BITS +: OUT_BITS])
    );
  end

  // -------------------------------------------------------------------------
  // Next-state logic: load FSM, counter, output register
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_done_d = 1'b0;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;

    case (state_q)
      IDLE: begin
        // A held output must drain first so the vector in flight was looked
        // up against one consistent set of tables.
        if (cfg_start && !m_valid_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cfg_valid) begin
          // Power-of-two ENTRIES: the increment past CNT_LAST wraps to 0.
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d    = IDLE;
            cfg_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = lut_rdata;
    end else if (m_ready) begin
      // m_data is left alone so the last result stays visible.
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cfg_done_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= cfg_done_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign cfg_busy = (state_q == LOAD);
  assign cfg_done = cfg_done_q;

endmodule

// File: tb/tb_logicnets_lut_layer_pipe.sv
// ---------------------------------------------------------------------------
// tb_logicnets_lut_layer_pipe
//   Self-checking bench for logicnets_lut_layer_pipe (default parameters).
//   Inputs are driven 1 time unit after each rising edge; all DUT outputs are
//   sampled on the falling edge. Accepted input vectors push their expected
//   result (from the bench's own table model) into a queue; the monitor pops
//   and compares whenever an output vector is accepted.
// ---------------------------------------------------------------------------
module tb_logicnets_lut_layer_pipe;

  localparam int NN      = 8;
  localparam int FI      = 6;
  localparam int OB      = 1;
  localparam int IW      = NN * FI;
  localparam int OW      = NN * OB;
  localparam int DEPTH   = 1 << FI;
  localparam int ENTRIES = NN * DEPTH;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [IW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [OW-1:0] m_data;
  logic          cfg_start;
  logic          cfg_valid;
  logic [OB-1:0] cfg_data;
  logic          cfg_busy;
  logic          cfg_done;

  int tests_run;
  int tests_failed;

  logic [OB-1:0] model_tbl [NN][DEPTH];
  logic [OB-1:0] new_tbl   [NN][DEPTH];
  logic [OW-1:0] exp_q [$];

  logicnets_lut_layer_pipe #(
    .NUM_NEURONS (NN),
    .FAN_IN      (FI),
    .OUT_BITS    (OB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_data  (cfg_data),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected layer output for one input vector, from the bench's tables.
  function automatic logic [OW-1:0] model_out(input logic [IW-1:0] d);
    logic [OW-1:0] r;
    logic [FI-1:0] a;
    r = '0;
    for (int n = 0; n < NN; n++) begin
      a = d[n*FI +: FI];
      r[n*OB +: OB] = model_tbl[n][a];
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] rand_vec();
    return IW'({$urandom(), $urandom()});
  endfunction

  // Scoreboard: pop/compare on output acceptance, push on input acceptance.
  task automatic scoreboard_monitor();
    logic [OW-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_extra: got m_data=%h, expected no output", m_data);
          end else begin
            exp_v = exp_q.pop_front();
            if (m_data !== exp_v) begin
              tests_failed++;
              $display("FAIL scoreboard_data: got m_data=%h, expected %h", m_data, exp_v);
            end
          end
        end
        if (s_valid === 1'b1 && s_ready === 1'b1) begin
          exp_q.push_back(model_out(s_data));
        end
      end
    end
  endtask

  // Waits (bounded) for all outstanding results to leave the DUT.
  task automatic wait_drain();
    m_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || m_valid === 1'b1); i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Full table load from new_tbl; copies new_tbl into the model when done.
  task automatic do_load(input bit gaps, input bit poke_start, input bit sv_during);
    int guard;
    int written;
    int busy_valid;
    int done_cnt;
    int sready_bad;
    @(posedge clk); #1;
    m_ready   = 1'b1;
    cfg_start = 1'b1;
    guard = 0;
    while (cfg_busy !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    cfg_start = 1'b0;
    tests_run++;
    if (cfg_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_start: cfg_busy=%b after %0d cycles, expected 1", cfg_busy, guard);
    end
    if (sv_during) begin
      s_valid = 1'b1;
      s_data  = rand_vec();
    end
    written    = 0;
    busy_valid = 0;
    done_cnt   = 0;
    sready_bad = 0;
    guard      = 0;
    while (written < ENTRIES && guard < 4 * ENTRIES) begin
      bit v;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cfg_valid = v;
      cfg_data  = new_tbl[written / DEPTH][written % DEPTH];
      cfg_start = poke_start && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (cfg_busy === 1'b1 && v) busy_valid++;
      if (cfg_done === 1'b1) done_cnt++;
      if (s_ready !== 1'b0) sready_bad++;
      @(posedge clk); #1;
      if (v) written++;
      guard++;
    end
    cfg_valid = 1'b0;
    cfg_start = 1'b0;
    model_tbl = new_tbl;
    tests_run++;
    if (cfg_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_busy_end: cfg_busy=%b after last entry, expected 0", cfg_busy);
    end
    tests_run++;
    if (cfg_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_done_pulse: cfg_done=%b after last entry, expected 1", cfg_done);
    end
    tests_run++;
    if (s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_ready_after: s_ready=%b in cfg_done cycle, expected 1", s_ready);
    end
    tests_run++;
    if (busy_valid != ENTRIES || done_cnt != 0) begin
      tests_failed++;
      $display("FAIL load_count: busy cfg_valid cycles=%0d done pulses=%0d, expected %0d and 0",
               busy_valid, done_cnt, ENTRIES);
    end
    tests_run++;
    if (sready_bad != 0) begin
      tests_failed++;
      $display("FAIL load_sready: s_ready high in %0d LOAD cycles, expected 0", sready_bad);
    end
    @(posedge clk); #1;
    tests_run++;
    if (cfg_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_done_width: cfg_done=%b one cycle later, expected 0", cfg_done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_m_valid: got %b, expected 0", m_valid);
    end
    tests_run++;
    if (m_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_m_data: got %h, expected 0", m_data);
    end
    tests_run++;
    if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_cfg: got busy=%b done=%b, expected 0 0", cfg_busy, cfg_done);
    end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = '0;
    @(negedge clk);
    tests_run++;
    if (s_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_s_ready: got %b, expected 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_first_lookup: got valid=%b data=%h, expected 1 00", m_valid, m_data);
    end
    @(posedge clk); #1;
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_drain: m_valid=%b, expected 0", m_valid);
    end
  endtask

  task automatic test_load_defaults();
    logic [FI-1:0] a;
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < DEPTH; i++) begin
        a = FI'(i);
        new_tbl[n][i] = (n == 0) ? OB'(^(a & 6'h2D)) : OB'(a[0]);
      end
    end
    do_load(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    logic [IW-1:0] v;
    m_ready = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      for (int n = 0; n < NN; n++) begin
        v[n*FI +: FI] = FI'((a + n * 11) % DEPTH);
      end
      s_valid = 1'b1;
      s_data  = v;
      @(negedge clk);
      tests_run++;
      if (s_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_ready: pattern %0d s_ready=%b, expected 1", a, s_ready);
      end
      if (a > 0) begin
        tests_run++;
        if (m_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL stream_throughput: pattern %0d m_valid=%b, expected 1", a, m_valid);
        end
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    wait_drain();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL stream_drain: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [IW-1:0] vec [8];
    logic [OW-1:0] held;
    int idx;
    for (int i = 0; i < 8; i++) vec[i] = rand_vec();
    idx  = 0;
    held = '0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      m_ready = !(c >= 1 && c <= 5);
      s_valid = 1'b1;
      s_data  = vec[idx];
      @(negedge clk);
      if (c >= 1 && c <= 5) begin
        tests_run++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_hold: cycle %0d s_ready=%b m_valid=%b, expected 0 1", c, s_ready, m_valid);
        end
        if (c >= 2) begin
          tests_run++;
          if (m_data !== held) begin
            tests_failed++;
            $display("FAIL bp_stable: cycle %0d m_data=%h, expected %h", c, m_data, held);
          end
        end
        held = m_data;
      end else begin
        tests_run++;
        if (s_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_throughput: cycle %0d s_ready=%b, expected 1", c, s_ready);
        end
      end
      if (s_valid === 1'b1 && s_ready === 1'b1) idx++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    wait_drain();
    tests_run++;
    if (idx != 8 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_complete: sent %0d outstanding %0d, expected 8 0", idx, exp_q.size());
    end
  endtask

  task automatic test_load_gating();
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++)
        new_tbl[n][i] = OB'($urandom());
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = rand_vec();
    @(posedge clk); #1;
    s_valid   = 1'b0;
    cfg_start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (cfg_busy !== 1'b0 || m_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL gate_hold: cycle %0d cfg_busy=%b m_valid=%b, expected 0 1", c, cfg_busy, m_valid);
      end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cfg_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL gate_drain_cycle: cfg_busy=%b, expected 0", cfg_busy);
    end
    @(posedge clk); #1;
    do_load(1'b0, 1'b0, 1'b1);
    s_valid = 1'b0;
    wait_drain();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL gate_complete: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_gapped_config();
    int k;
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++)
        new_tbl[n][i] = OB'($urandom());
    do_load(1'b1, 1'b1, 1'b0);
    k = 0;
    s_data = rand_vec();
    for (int c = 0; c < 400 && k < 40; c++) begin
      s_valid = 1'b1;
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (s_valid === 1'b1 && s_ready === 1'b1) k++;
      @(posedge clk); #1;
      if (k > 0) s_data = rand_vec();
    end
    s_valid = 1'b0;
    wait_drain();
    tests_run++;
    if (k != 40 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL gapped_stream: sent %0d outstanding %0d, expected 40 0", k, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    int guard;
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++)
        new_tbl[n][i] = '1;
    m_ready = 1'b1;
    s_valid = 1'b0;
    @(posedge clk); #1;
    cfg_start = 1'b1;
    guard = 0;
    while (cfg_busy !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    cfg_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = new_tbl[i / DEPTH][i % DEPTH];
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++)
        model_tbl[n][i] = '0;
    #1;
    tests_run++;
    if (cfg_busy !== 1'b0 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midload_reset: cfg_busy=%b m_valid=%b, expected 0 0", cfg_busy, m_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_valid = 1'b1;
      s_data  = rand_vec();
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if (m_data !== '0) begin
      tests_failed++;
      $display("FAIL midload_lookup: m_data=%h, expected 0", m_data);
    end
    wait_drain();
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++)
        new_tbl[n][i] = OB'($urandom());
    do_load(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++) begin
      s_valid = 1'b1;
      s_data  = rand_vec();
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    wait_drain();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL midload_restart: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    s_valid      = 1'b0;
    s_data       = '0;
    m_ready      = 1'b1;
    cfg_start    = 1'b0;
    cfg_valid    = 1'b0;
    cfg_data     = '0;
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < DEPTH; i++)
        model_tbl[n][i] = '0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_load_defaults();
    test_stream();
    test_backpressure();
    test_load_gating();
    test_gapped_config();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
